// File: rtl/mlp_pkg.sv
// Shared widths, neuron sequencer state encoding and a width-parameterised saturating adder
// for the MLP datapath.
package mlp_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        S_IN   = 3'd0,
        S_MUL  = 3'd1,
        S_ACC  = 3'd2,
        S_BIAS = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    // Adds two unsigned operands and clamps at 2^w-1; valid for w up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/shift_add_mult8.sv
// 8x8 unsigned shift-add multiplier with a fixed 8-cycle latency after start.
// done is high during the last processing cycle; product is final one edge later.
module shift_add_mult8
    import mlp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [PROD_W-1:0]   product,
    output logic                done
);

    logic [PROD_W-1:0] a_sh;
    logic [DATA_W-1:0] b_sh;
    logic [2:0]        bit_cnt;
    logic              running;

    assign done = running && (bit_cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            product <= '0;
            bit_cnt <= '0;
            running <= 1'b0;
        end else if (start) begin
            a_sh    <= {{(PROD_W-DATA_W){1'b0}}, a};
            b_sh    <= b;
            product <= '0;
            bit_cnt <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (b_sh[0])
                product <= product + a_sh;
            a_sh    <= a_sh << 1;
            b_sh    <= b_sh >> 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Neuron MAC sequencer: accumulates N_INPUTS products, adds bias, scales and saturates.
// Optional macro NEURON_ROUND_EN selects round-half-up scaling instead of truncation.
//
// state  | meaning
// S_IN   | waiting for next (x, w) pair, in_ready high
// S_MUL  | 8-cycle shift-add multiply in progress
// S_ACC  | add product into accumulator, advance pair count
// S_BIAS | add bias, register scaled output
// S_OUT  | result valid, waiting for out_ready
module neuron_mac_seq
    import mlp_pkg::*;
#(
    parameter int N_INPUTS  = 4,
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_x,
    input  logic [7:0]          in_w,
    input  logic [15:0]         bias,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_y,
    output logic [ACC_W-1:0]    out_acc,
    output logic                busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int SC_W  = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N_INPUTS - 1);

    state_t              state;
    logic [CNT_W-1:0]    pair_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_prod;
    logic [ACC_W-1:0]    acc_bias;
    logic [SC_W-1:0]     scaled;
    logic [7:0]          y_next;
    logic [PROD_W-1:0]   product;
    logic                mul_start;
    logic                mul_done;

    assign in_ready  = (state == S_IN);
    assign out_valid = (state == S_OUT);
    assign busy      = !((state == S_IN) && (pair_cnt == '0));
    // A pair arriving together with flush is dropped, so the multiplier is not started.
    assign mul_start = in_valid && in_ready && !flush;

    shift_add_mult8 u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in_x),
        .b       (in_w),
        .product (product),
        .done    (mul_done)
    );

    assign acc_prod = ACC_W'(sat_add(32'(acc), 32'(product), ACC_W));
    assign acc_bias = ACC_W'(sat_add(32'(acc), 32'(bias), ACC_W));

    always_comb begin
`ifdef NEURON_ROUND_EN
        scaled = ({1'b0, acc_bias} + SC_W'(2 ** (OUT_SHIFT - 1))) >> OUT_SHIFT;
`else
        scaled = {1'b0, acc_bias} >> OUT_SHIFT;
`endif
        y_next = (scaled > SC_W'(255)) ? 8'hFF : scaled[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IN;
            pair_cnt <= '0;
            acc      <= '0;
            out_y    <= '0;
            out_acc  <= '0;
        end else if (flush) begin
            state    <= S_IN;
            pair_cnt <= '0;
            acc      <= '0;
        end else begin
            case (state)
                S_IN: begin
                    if (in_valid)
                        state <= S_MUL;
                end
                S_MUL: begin
                    if (mul_done)
                        state <= S_ACC;
                end
                S_ACC: begin
                    acc <= acc_prod;
                    if (pair_cnt == LAST_PAIR) begin
                        state <= S_BIAS;
                    end else begin
                        pair_cnt <= pair_cnt + 1'b1;
                        state    <= S_IN;
                    end
                end
                S_BIAS: begin
                    acc     <= acc_bias;
                    out_acc <= acc_bias;
                    out_y   <= y_next;
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        state    <= S_IN;
                        pair_cnt <= '0;
                        acc      <= '0;
                    end
                end
                default: state <= S_IN;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed scoreboard bench for neuron_mac_seq; expected results come from a behavioural
// model honouring NEURON_ROUND_EN.
module tb_neuron_mac_seq;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int SH = 4;

    typedef logic [7:0] vec_t [N];
    typedef struct {
        logic [31:0] acc;
        logic [7:0]  y;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_x = '0;
    logic [7:0]    in_w = '0;
    logic [15:0]   bias = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_y;
    logic [AW-1:0] out_acc;
    logic          busy;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    neuron_mac_seq #(.N_INPUTS(N), .ACC_W(AW), .OUT_SHIFT(SH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_acc   (out_acc),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input vec_t xs, input vec_t ws, input logic [15:0] b);
        exp_t    e;
        longint  a = 0;
        longint  s;
        longint  max_v = (longint'(1) << AW) - 1;
        for (int i = 0; i < N; i++) begin
            a = a + longint'(xs[i]) * longint'(ws[i]);
            if (a > max_v) a = max_v;
        end
        a = a + longint'(b);
        if (a > max_v) a = max_v;
        s = a;
`ifdef NEURON_ROUND_EN
        s = s + (longint'(1) << (SH - 1));
`endif
        s = s >> SH;
        e.acc = 32'(a);
        e.y   = (s > 255) ? 8'hFF : 8'(s);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send_pair(input logic [7:0] x, input logic [7:0] w, input int gap,
                             output int acc_cyc);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            in_x = 8'($urandom);
            in_w = 8'($urandom);
        end
        @(negedge clk);
        while (!in_ready && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_x     = 8'($urandom);
        in_w     = 8'($urandom);
    endtask

    task automatic run_vector(input vec_t xs, input vec_t ws, input logic [15:0] b,
                              input int gap_max, output int first_cyc);
        int c;
        sb.push_back(model(xs, ws, b));
        bias = b;
        for (int i = 0; i < N; i++) begin
            send_pair(xs[i], ws[i], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0, c);
            if (i == 0) first_cyc = c;
        end
    endtask

    task automatic wait_out(input string tag, input int hold, input int first_cyc,
                            input bit chk_lat);
        int   t = 0;
        exp_t e;
        logic prev_ready;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 400);
        if (!out_valid) begin
            check({tag, "_out_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        e = sb.pop_front();
        if (chk_lat) check({tag, "_latency"}, 32'(cyc - first_cyc), 32'd40);
        check({tag, "_acc"}, 32'(out_acc), e.acc);
        check({tag, "_y"}, 32'(out_y), 32'(e.y));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_acc"}, 32'(out_acc), e.acc);
            check({tag, "_hold_y"}, 32'(out_y), 32'(e.y));
        end
        prev_ready = out_ready;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = prev_ready;
        @(negedge clk);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_y_held"}, 32'(out_y), 32'(e.y));
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t xs, ws;
        int   first, c;
        logic [15:0] b;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_acc", 32'(out_acc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic vector, out_ready held high throughout
        out_ready = 1'b1;
        xs = '{8'd1, 8'd2, 8'd3, 8'd4};
        ws = '{8'd10, 8'd20, 8'd30, 8'd40};
        run_vector(xs, ws, 16'd20, 0, first);
        wait_out("basic", 0, first, 1'b1);
        out_ready = 1'b0;

        // output saturation
        xs = '{8'd255, 8'd255, 8'd255, 8'd255};
        run_vector(xs, xs, 16'd0, 0, first);
        wait_out("sat", 0, first, 1'b1);

        // rounding boundary: acc = 24
        xs = '{8'd4, 8'd1, 8'd1, 8'd1};
        ws = '{8'd6, 8'd0, 8'd0, 8'd0};
        run_vector(xs, ws, 16'd0, 0, first);
        wait_out("round", 0, first, 1'b1);

        // backpressure for 5 cycles, then a follow-up vector
        xs = '{8'd9, 8'd8, 8'd7, 8'd6};
        ws = '{8'd100, 8'd50, 8'd25, 8'd12};
        run_vector(xs, ws, 16'd1000, 0, first);
        wait_out("bp", 5, first, 1'b1);
        xs = '{8'd1, 8'd2, 8'd3, 8'd4};
        ws = '{8'd10, 8'd20, 8'd30, 8'd40};
        run_vector(xs, ws, 16'd20, 0, first);
        wait_out("bp_next", 0, first, 1'b1);

        // flush during the third S_MUL cycle of pair 2
        bias = 16'd20;
        send_pair(8'd50, 8'd50, 0, c);
        send_pair(8'd60, 8'd60, 0, c);
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);

        // flush coinciding with a handshake drops the pair
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_x     = 8'd200;
        in_w     = 8'd200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_hs_in_ready", 32'(in_ready), 32'd1);
        check("flush_hs_busy", 32'(busy), 32'd0);
        run_vector(xs, ws, 16'd20, 0, first);
        wait_out("after_flush", 0, first, 1'b1);

        // async reset while in S_ACC
        send_pair(8'd5, 8'd5, 0, c);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_y", 32'(out_y), 32'd0);
        check("arst_out_acc", 32'(out_acc), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // random idle gaps between handshakes
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = 8'($urandom);
                ws[i] = 8'($urandom);
            end
            b = 16'($urandom);
            run_vector(xs, ws, b, 4, first);
            wait_out("gaps", int'($urandom_range(3, 0)), first, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
